mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the shared data-memory arbiter.
interface mem_arbiter_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    // Requester side
    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0]             we;
    logic [N_REQ-1:0][ADDR_W-1:0] addr;
    logic [N_REQ-1:0][DATA_W-1:0] wdata;
    logic [N_REQ-1:0]             gnt;
    logic [N_REQ-1:0]             rvalid;
    logic [DATA_W-1:0]            rdata;

    // Memory side
    logic                         mem_read;
    logic                         mem_write;
    logic [ADDR_W-1:0]            mem_addr;
    logic [DATA_W-1:0]            mem_d_in;
    logic [DATA_W-1:0]            mem_d_out;

    // Arbiter view
    modport slave (
        input  req, we, addr, wdata, mem_d_out,
        output gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_d_in
    );

    // Requester / memory-model view
    modport master (
        output req, we, addr, wdata, mem_d_out,
        input  gnt, rvalid, rdata, mem_read, mem_write, mem_addr, mem_d_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting N_REQ requesters bursts of single-cycle
// accesses to one data memory with a fixed one-cycle read latency.
module mem_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   owner_q, owner_n;
    logic [IDX_W-1:0]   last_owner_q, last_owner_n;
    logic [CNT_W-1:0]   burst_q, burst_n, burst_inc;
    logic [N_REQ-1:0]   gnt_q, gnt_n;
    logic [N_REQ-1:0]   rvalid_q, rvalid_n;
    logic [N_REQ-1:0]   others;
    logic [IDX_W-1:0]   pick, cand;
    logic               pick_valid;
    logic               issue;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first requester after last_owner, wrapping.
    always_comb begin
        pick       = '0;
        cand       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(last_owner_q) + k) % N_REQ);
            if (!pick_valid && bus.req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Memory-side mux: only the owner's fields can reach the memory bus.
    always_comb begin
        issue         = !reset && (state_q == BUSY) && bus.req[owner_q];
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_d_in  = '0;
        if (issue) begin
            bus.mem_read  = !bus.we[owner_q];
            bus.mem_write = bus.we[owner_q];
            bus.mem_addr  = bus.addr[owner_q];
            bus.mem_d_in  = bus.wdata[owner_q];
        end
    end

    // Next-state logic: grant, burst accounting and release decisions.
    always_comb begin
        state_n      = state_q;
        owner_n      = owner_q;
        last_owner_n = last_owner_q;
        burst_n      = burst_q;
        gnt_n        = gnt_q;
        rvalid_n     = '0;
        others       = bus.req & ~onehot(owner_q);
        burst_inc    = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 8'd1;

        if (issue && !bus.we[owner_q]) begin
            rvalid_n = onehot(owner_q);
        end

        case (state_q)
            IDLE: begin
                gnt_n = '0;
                if (pick_valid) begin
                    state_n = BUSY;
                    owner_n = pick;
                    gnt_n   = onehot(pick);
                    burst_n = '0;
                end
            end
            BUSY: begin
                if (!bus.req[owner_q]) begin
                    // Owner finished: release with a one-cycle bubble.
                    state_n      = IDLE;
                    gnt_n        = '0;
                    last_owner_n = owner_q;
                    burst_n      = '0;
                end else if (burst_inc == BURST_MAX) begin
                    burst_n = '0;
                    if (|others) begin
                        // Burst limit hit while someone waits: forced release.
                        state_n      = IDLE;
                        gnt_n        = '0;
                        last_owner_n = owner_q;
                    end
                end else begin
                    burst_n = burst_inc;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            burst_q      <= '0;
            gnt_q        <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_n;
            owner_q      <= owner_n;
            last_owner_q <= last_owner_n;
            burst_q      <= burst_n;
            gnt_q        <= gnt_n;
            rvalid_q     <= rvalid_n;
        end
    end

    // Registered grant/strobe; read data is the memory's one-cycle-late output.
    assign bus.gnt    = gnt_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = bus.mem_d_out;

    // Structural invariants of the grant and memory strobes.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt_q));
    a_rw_excl    : assert property (@(posedge clk) disable iff (reset) !(bus.mem_read && bus.mem_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small memory model.
module tb_mem_arbiter;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned MAX_BURST = 8;
    localparam int          STARVE_LIM = (N_REQ - 1) * (MAX_BURST + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;

    mem_arbiter_if #(.N_REQ(N_REQ)) bus ();

    mem_arbiter #(.N_REQ(N_REQ), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: contents reload to 0xBEAF ^ addr while reset is high.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hBEAF ^ 16'(i);
            bus.mem_d_out <= '0;
        end else begin
            if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_d_in;
            if (bus.mem_read)  bus.mem_d_out <= mem[bus.mem_addr[7:0]];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.req   = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    int          acc, bub, wr, grants, max_wait;
    int          wait_c [N_REQ];
    bit          waiting [N_REQ];
    logic [3:0]  exp_g, prev_rd;

    initial begin
        // Reset state, including req asserted while reset is held.
        reset   = 1'b1;
        bus.req = 4'b1111;
        bus.we  = 4'b0000;
        bus.addr = '0;
        bus.wdata = '0;
        repeat (2) tick();
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_rvalid", bus.rvalid, 4'b0000);
        check("rst_rd", bus.mem_read, 1'b0);
        check("rst_wr", bus.mem_write, 1'b0);

        // Single requester held 20 cycles: continuous accesses, no bubble.
        do_reset();
        bus.req     = 4'b0001;
        bus.addr[0] = 16'h0010;
        #1 check("r028_pre_gnt", bus.gnt, 4'b0000);
        tick();
        acc = 0;
        bub = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.mem_read) acc++;
            if (bus.gnt != 4'b0001) bub++;
            if (i == 1) begin
                check("r028_rvalid", bus.rvalid, 4'b0001);
                check("r028_rdata", bus.rdata, 16'hBEBF);
            end
            tick();
        end
        check("r028_accesses", acc, 20);
        check("r028_bubbles", bub, 0);

        // All four requesting: 0,1,2,3,0 with 8 accesses each and 1 idle cycle.
        do_reset();
        bus.req = 4'b1111;
        acc = 0;
        for (int k = 0; k < 45; k++) begin
            #1;
            if (k == 0 || (k - 1) % 9 == 8) exp_g = 4'b0000;
            else exp_g = 4'b0001 << (((k - 1) / 9) % 4);
            check($sformatf("r029_gnt_c%0d", k), bus.gnt, exp_g);
            if (bus.mem_read) acc++;
            tick();
        end
        check("r029_accesses", acc, 40);

        // Single read by requester 1 with X on non-owner fields.
        do_reset();
        bus.req      = 4'b0010;
        bus.we       = 4'b000x;
        bus.addr[1]  = 16'h0040;
        bus.wdata[1] = 16'h5555;
        bus.addr[0]  = 'x;
        bus.wdata[0] = 'x;
        bus.addr[2]  = 'x;
        tick();
        #1;
        check("r030_gnt", bus.gnt, 4'b0010);
        check("r030_rd", bus.mem_read, 1'b1);
        check("r030_wr", bus.mem_write, 1'b0);
        check("r030_addr", bus.mem_addr, 16'h0040);
        check("r024_din", bus.mem_d_in, 16'h5555);
        tick();
        bus.req = 4'b0000;
        #1;
        check("r030_rvalid", bus.rvalid, 4'b0010);
        check("r030_rdata", bus.rdata, 16'hBEEF);
        check("r030_idle_rd", bus.mem_read, 1'b0);
        tick();
        check("r030_rvalid_off", bus.rvalid, 4'b0000);
        check("r030_gnt_off", bus.gnt, 4'b0000);

        // Owner 0 writes 3 words then drops; requester 3 follows after a bubble.
        do_reset();
        bus.we  = 4'b0001;
        bus.req = 4'b1001;
        tick();
        wr = 0;
        for (int i = 0; i < 3; i++) begin
            bus.addr[0]  = 16'(16'h0100 + i);
            bus.wdata[0] = 16'(16'h1111 * (i + 1));
            bus.req[2]   = (i == 1);
            #1;
            check($sformatf("r031_gnt_w%0d", i), bus.gnt, 4'b0001);
            check($sformatf("r031_din_w%0d", i), bus.mem_d_in, 16'(16'h1111 * (i + 1)));
            if (bus.mem_write) wr++;
            tick();
        end
        bus.req = 4'b1000;
        #1;
        check("r031_no_wr", bus.mem_write, 1'b0);
        check("r031_gnt_drop", bus.gnt, 4'b0001);
        tick();
        check("r031_bubble", bus.gnt, 4'b0000);
        tick();
        check("r031_gnt3", bus.gnt, 4'b1000);
        check("r031_writes", wr, 3);
        check("r031_mem0", mem[8'h00], 16'h1111);
        check("r031_mem1", mem[8'h01], 16'h2222);
        check("r031_mem2", mem[8'h02], 16'h3333);

        // Reset asserted mid-cycle during a requester 2 read burst.
        do_reset();
        bus.req     = 4'b0100;
        bus.we      = 4'b0000;
        bus.addr[2] = 16'h0020;
        tick();
        #1;
        check("r032_gnt", bus.gnt, 4'b0100);
        check("r032_rd", bus.mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("r032_async_gnt", bus.gnt, 4'b0000);
        check("r032_async_rvalid", bus.rvalid, 4'b0000);
        check("r032_async_rd", bus.mem_read, 1'b0);
        check("r032_async_wr", bus.mem_write, 1'b0);
        tick();
        check("r032_inflight_rvalid", bus.rvalid, 4'b0000);
        check("r032_held_rd", bus.mem_read, 1'b0);
        reset = 1'b0;
        tick();
        check("r032_regrant", bus.gnt, 4'b0100);

        // Random traffic: invariants, read-valid timing and starvation bound.
        do_reset();
        prev_rd  = '0;
        grants   = 0;
        max_wait = 0;
        for (int b = 0; b < N_REQ; b++) begin
            wait_c[b]  = 0;
            waiting[b] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_REQ; b++) begin
                if ($urandom_range(7) == 0) bus.req[b] = ~bus.req[b];
                bus.addr[b]  = 16'($urandom);
                bus.wdata[b] = 16'($urandom);
            end
            bus.we = 4'($urandom);
            #1;
            check("r023_onehot", 32'($countones(bus.gnt) <= 1), 1);
            check("r023_excl", bus.mem_read & bus.mem_write, 1'b0);
            check("r016_issue", bus.mem_read | bus.mem_write, |(bus.gnt & bus.req));
            check("r021_rvalid", bus.rvalid, prev_rd);
            prev_rd = bus.mem_read ? bus.gnt : 4'b0000;
            if (bus.mem_read | bus.mem_write) grants++;
            for (int b = 0; b < N_REQ; b++) begin
                if (bus.req[b] && !bus.gnt[b]) begin
                    if (waiting[b]) wait_c[b]++;
                    else begin
                        waiting[b] = 1'b1;
                        wait_c[b]  = 0;
                    end
                    if (wait_c[b] > max_wait) max_wait = wait_c[b];
                end else begin
                    waiting[b] = 1'b0;
                end
            end
            tick();
        end
        check("r033_starve", 32'(max_wait <= STARVE_LIM), 1);
        check("r033_activity", 32'(grants > 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
